// File: rtl/seq_table_counter_pkg.sv
// Shared defaults and helpers for the programmable sequence counter.
package seq_table_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    // Effective sequence length: a length of 0 or beyond the table means the whole table.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned depth);
        return ((len == 0) || (len > depth)) ? depth : len;
    endfunction

    // Effective loop point: a loop index outside the active sequence falls back to entry 0.
    function automatic int unsigned eff_loop(input int unsigned loop_idx, input int unsigned l);
        return (loop_idx < l) ? loop_idx : 0;
    endfunction

endpackage

// File: rtl/seq_table_counter_table.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read, synchronous clear.
module seq_table
    import seq_table_counter_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Each entry clears on reset and loads only when addressed by a write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == IW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rd_data = entries[rd_addr];

endmodule

// File: rtl/seq_table_counter.sv
// Table-driven sequence counter: walks a programmable code table with a
// configurable length and loop-back point, one step per enabled cycle.
module seq_table_counter
    import seq_table_counter_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW:0]      len,
    input  logic [IW-1:0]    loop_idx,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrapped
);

    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             wrapped_reg, wrapped_next;
    logic             load;
    logic [WIDTH-1:0] rd_data;
    int unsigned      len_eff, loop_eff;

    // The table is read at the index about to be loaded so q lands with idx.
    seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_next),
        .rd_data (rd_data)
    );

    // Next-index selection: restart beats advance; an index at or past the
    // last active entry (len may shrink mid-run) re-enters the loop point.
    always_comb begin
        idx_next     = idx_reg;
        wrapped_next = 1'b0;
        load         = 1'b0;
        len_eff      = eff_len(32'(len), unsigned'(DEPTH));
        loop_eff     = eff_loop(32'(loop_idx), len_eff);
        if (restart) begin
            idx_next = '0;
            load     = 1'b1;
        end else if (en) begin
            load = 1'b1;
            if (32'(idx_reg) >= (len_eff - 1)) begin
                idx_next     = IW'(loop_eff);
                wrapped_next = 1'b1;
            end else begin
                idx_next = idx_reg + IW'(1);
            end
        end
    end

    // Write-through bypass: a write to the entry being loaded reaches q immediately.
    always_comb begin
        q_next = rd_data;
        if (wr_en && (wr_addr == idx_next)) begin
            q_next = wr_data;
        end
    end

    // Output registers; on hold idx and q keep their values and wrapped drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg     <= '0;
            q_reg       <= '0;
            wrapped_reg <= 1'b0;
        end else begin
            wrapped_reg <= wrapped_next;
            if (load) begin
                idx_reg <= idx_next;
                q_reg   <= q_next;
            end
        end
    end

    assign q       = q_reg;
    assign idx     = idx_reg;
    assign wrapped = wrapped_reg;

endmodule
